// File: rtl/byte_display_sequencer.sv
// Presents a captured 16-byte block one byte at a time, DWELL cycles per byte,
// with a registered BCD rendering of the byte on show.
module byte_display_sequencer #(
   parameter int unsigned DWELL = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [127:0] block_in,
   output logic         busy,
   output logic [3:0]   byte_idx,
   output logic [7:0]   byte_val,
   output logic [11:0]  bcd_out,
   output logic         bcd_valid,
   output logic         done
);

   localparam int unsigned CW       = $clog2(DWELL);
   localparam int unsigned BLOCK_W  = 128;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned IDX_W    = 4;
   localparam int unsigned BCD_W    = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [BYTE_W-1:0]    byte_q, byte_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic [BLOCK_W-1:0]   block_q, block_d;
   logic                 busy_q, busy_d;
   logic                 valid_q, valid_d;
   logic                 done_q, done_d;

   logic [BCD_W-1:0]     bcd_c;
   logic [IDX_W-1:0]     idx_inc_c;
   logic [6:0]           sel_c;
   logic                 last_dwell_c;

   // Double-dabble: shift the byte through three BCD digits, adding 3 to any digit >= 5.
   function automatic logic [BCD_W-1:0] bin2bcd(input logic [BYTE_W-1:0] bin);
      logic [19:0] sr;
      sr = {12'd0, bin};
      for (int i = 0; i < 8; i++) begin
         if (sr[11:8]  > 4'd4) sr[11:8]  = sr[11:8]  + 4'd3;
         if (sr[15:12] > 4'd4) sr[15:12] = sr[15:12] + 4'd3;
         if (sr[19:16] > 4'd4) sr[19:16] = sr[19:16] + 4'd3;
         sr = {sr[18:0], 1'b0};
      end
      return sr[19:8];
   endfunction

   always_comb begin
      bcd_c = bin2bcd(byte_q);
   end

   // Byte k sits at block[127-8k -: 8]; 15-k equals ~k in four bits.
   always_comb begin
      idx_inc_c    = idx_q + 4'd1;
      sel_c        = {~idx_inc_c, 3'b000};
      last_dwell_c = (cnt_q == CW'(DWELL - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         byte_q  <= '0;
         bcd_q   <= '0;
         block_q <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         byte_q  <= byte_d;
         bcd_q   <= bcd_d;
         block_q <= block_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      byte_d  = byte_q;
      bcd_d   = bcd_q;
      block_d = block_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = SHOW;
               block_d = block_in;
               idx_d   = '0;
               cnt_d   = '0;
               byte_d  = block_in[127:120];
            end
         end
         SHOW: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               bcd_d = bcd_c;
               if (last_dwell_c) begin
                  cnt_d = '0;
                  if (idx_q == 4'd15) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     idx_d  = idx_inc_c;
                     byte_d = block_q[sel_c +: 8];
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags follow the next state so they line up with the registered data.
      busy_d  = (state_d == SHOW);
      valid_d = (state_d == SHOW) && (cnt_d != '0);
   end

   assign busy      = busy_q;
   assign byte_idx  = idx_q;
   assign byte_val  = byte_q;
   assign bcd_out   = bcd_q;
   assign bcd_valid = valid_q;
   assign done      = done_q;

endmodule

// File: tb/tb_byte_display_sequencer.sv
// Directed bench for byte_display_sequencer at DWELL=4: full run, ignored
// restart, abort, asynchronous reset and start+abort collision.
module tb_byte_display_sequencer;

   logic         clk;
   logic         rst;
   logic         start;
   logic         abort;
   logic [127:0] block_in;
   logic         busy;
   logic [3:0]   byte_idx;
   logic [7:0]   byte_val;
   logic [11:0]  bcd_out;
   logic         bcd_valid;
   logic         done;

   int n_tests;
   int n_fail;

   localparam logic [127:0] BLK = 128'h0170FB00_9C2DFF64_7CEB3209_0A63C880;

   logic [7:0]  exp_byte [16] = '{8'd1, 8'd112, 8'd251, 8'd0, 8'd156, 8'd45, 8'd255, 8'd100,
                                  8'd124, 8'd235, 8'd50, 8'd9, 8'd10, 8'd99, 8'd200, 8'd128};
   logic [11:0] exp_bcd  [16] = '{12'h001, 12'h112, 12'h251, 12'h000, 12'h156, 12'h045, 12'h255, 12'h100,
                                  12'h124, 12'h235, 12'h050, 12'h009, 12'h010, 12'h099, 12'h200, 12'h128};

   byte_display_sequencer #(.DWELL(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .block_in  (block_in),
      .busy      (busy),
      .byte_idx  (byte_idx),
      .byte_val  (byte_val),
      .bcd_out   (bcd_out),
      .bcd_valid (bcd_valid),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".busy"},  32'(busy),      0);
      check({tag, ".done"},  32'(done),      0);
      check({tag, ".valid"}, 32'(bcd_valid), 0);
      check({tag, ".idx"},   32'(byte_idx),  0);
      check({tag, ".byte"},  32'(byte_val),  0);
      check({tag, ".bcd"},   32'(bcd_out),   0);
   endtask

   initial begin
      logic [3:0] ei;
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      block_in = '0;

      // Reset state, asserted before any clock edge
      #1 rst = 1'b1;
      #1 check_reset_outputs("rst0");
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Full run with a restart attempt mid-sequence
      block_in = BLK;
      start    = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 64; c++) begin
         ei = 4'((c - 1) / 4);
         check("run.busy",  32'(busy),      1);
         check("run.done",  32'(done),      0);
         check("run.idx",   32'(byte_idx),  32'(ei));
         check("run.byte",  32'(byte_val),  32'(exp_byte[ei]));
         check("run.valid", 32'(bcd_valid), 32'(((c - 1) % 4) != 0));
         if (((c - 1) % 4) != 0) check("run.bcd", 32'(bcd_out), 32'(exp_bcd[ei]));
         if (c == 20) begin
            start    = 1'b1;
            block_in = ~BLK;
         end
         if (c == 21) begin
            start    = 1'b0;
            block_in = BLK;
         end
         tick();
      end
      check("fin.done",  32'(done),      1);
      check("fin.busy",  32'(busy),      0);
      check("fin.valid", 32'(bcd_valid), 0);
      tick();
      check("idle.done", 32'(done),      0);
      check("idle.busy", 32'(busy),      0);
      check("idle.idx",  32'(byte_idx),  15);
      check("idle.byte", 32'(byte_val),  128);
      check("idle.bcd",  32'(bcd_out),   'h128);
      tick();
      check("idle2.busy", 32'(busy), 0);

      // Abort during byte 2
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      check("ab.pre_idx", 32'(byte_idx), 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab.busy",  32'(busy),      0);
      check("ab.valid", 32'(bcd_valid), 0);
      check("ab.done",  32'(done),      0);
      check("ab.idx",   32'(byte_idx),  2);
      check("ab.byte",  32'(byte_val),  251);
      check("ab.bcd",   32'(bcd_out),   'h251);
      for (int c = 0; c < 4; c++) begin
         tick();
         check("ab.nodone", 32'(done), 0);
         check("ab.idle",   32'(busy), 0);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rs.busy", 32'(busy),     1);
      check("rs.idx",  32'(byte_idx), 0);
      check("rs.byte", 32'(byte_val), 1);

      // Asynchronous reset between edges mid-sequence
      for (int c = 1; c < 7; c++) tick();
      check("pre_rst.idx", 32'(byte_idx), 1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("arst");
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("post_rst.busy", 32'(busy), 0);
         check("post_rst.done", 32'(done), 0);
         check("post_rst.idx",  32'(byte_idx), 0);
      end

      // start and abort together in IDLE: abort wins
      start = 1'b1;
      abort = 1'b1;
      tick();
      check("sa.busy", 32'(busy), 0);
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("sa.busy2", 32'(busy),     0);
      check("sa.byte",  32'(byte_val), 0);
      tick();
      check("sa.done", 32'(done), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
